// File: rtl/afpm_host_link.sv
// Host-side link controller for a byte-serial binary16 multiplier: sends both
// operands as two byte pairs, waits a fixed dwell, then captures the 16-bit result.
module afpm_host_link #(
  parameter int unsigned RSP_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic        abort,
  output logic        link_en,
  output logic [7:0]  tx_a,
  output logic [7:0]  tx_b,
  input  logic [7:0]  rx_byte,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  input  logic        rsp_ready,
  output logic        busy,
  output logic [7:0]  txn_count
);

  typedef enum logic [2:0] {
    IDLE, SEND_LO, SEND_HI, WAIT, CAP_LO, CAP_HI, RESP
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(RSP_WAIT - 1);

  state_t      state, state_nx;
  logic [15:0] op_a, op_b;
  logic [3:0]  wait_cnt;
  logic [15:0] rsp_q;
  logic [7:0]  cnt_q;
  logic        accept, done;

  assign accept = (state == IDLE) && req_valid && !abort;
  assign done   = (state == RESP) && rsp_ready && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort && state != IDLE) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (accept) state_nx = SEND_LO;
        SEND_LO: state_nx = SEND_HI;
        SEND_HI: state_nx = WAIT;
        WAIT:    if (wait_cnt == 4'd0) state_nx = CAP_LO;
        CAP_LO:  state_nx = CAP_HI;
        CAP_HI:  state_nx = RESP;
        RESP:    if (done) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Dwell counter is loaded on the SEND_HI->WAIT edge so WAIT lasts RSP_WAIT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a     <= '0;
      op_b     <= '0;
      wait_cnt <= '0;
      rsp_q    <= '0;
      cnt_q    <= '0;
    end else begin
      if (accept) begin
        op_a <= req_a;
        op_b <= req_b;
      end
      if (state == SEND_HI)
        wait_cnt <= WAIT_LOAD;
      else if (state == WAIT && wait_cnt != 4'd0)
        wait_cnt <= wait_cnt - 4'd1;
      if (state == CAP_LO && !abort) rsp_q[7:0]  <= rx_byte;
      if (state == CAP_HI && !abort) rsp_q[15:8] <= rx_byte;
      if (done) cnt_q <= cnt_q + 8'd1;
    end
  end

  always_comb begin
    tx_a = '0;
    tx_b = '0;
    if (state == SEND_LO) begin
      tx_a = op_a[7:0];
      tx_b = op_b[7:0];
    end else if (state == SEND_HI) begin
      tx_a = op_a[15:8];
      tx_b = op_b[15:8];
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign link_en   = (state == SEND_LO) || (state == SEND_HI) || (state == WAIT) ||
                     (state == CAP_LO)  || (state == CAP_HI);
  assign rsp_valid = (state == RESP);
  assign rsp_data  = rsp_q;
  assign txn_count = cnt_q;

endmodule

// File: tb/tb_afpm_host_link.sv
// Directed bench for afpm_host_link: byte sequencing, latency, backpressure,
// abort, mid-transaction reset, counter wrap and RSP_WAIT extremes.
module tb_afpm_host_link;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid, req_valid1, req_valid15, abort, rsp_ready;
  logic [15:0] req_a, req_b;
  logic [7:0]  rx_seed, rx_byte;
  logic [7:0]  lcnt = '0;

  logic        req_ready, link_en, rsp_valid, busy;
  logic [7:0]  tx_a, tx_b, txn_count;
  logic [15:0] rsp_data;

  logic        req_ready_1, link_en_1, rsp_valid_1, busy_1;
  logic [7:0]  tx_a_1, tx_b_1, txn_count_1;
  logic [15:0] rsp_data_1;
  logic        req_ready_15, link_en_15, rsp_valid_15, busy_15;
  logic [7:0]  tx_a_15, tx_b_15, txn_count_15;
  logic [15:0] rsp_data_15;

  // Result stub: byte value tracks how many link cycles the main DUT has run.
  assign rx_byte = rx_seed + lcnt;
  always @(posedge clk) lcnt <= link_en ? lcnt + 8'd1 : 8'd0;

  afpm_host_link #(.RSP_WAIT(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .abort(abort), .link_en(link_en),
    .tx_a(tx_a), .tx_b(tx_b), .rx_byte(rx_byte), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready), .busy(busy), .txn_count(txn_count)
  );

  afpm_host_link #(.RSP_WAIT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready_1),
    .req_a(req_a), .req_b(req_b), .abort(abort), .link_en(link_en_1),
    .tx_a(tx_a_1), .tx_b(tx_b_1), .rx_byte(rx_byte), .rsp_valid(rsp_valid_1),
    .rsp_data(rsp_data_1), .rsp_ready(rsp_ready), .busy(busy_1), .txn_count(txn_count_1)
  );

  afpm_host_link #(.RSP_WAIT(15)) u_dut15 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid15), .req_ready(req_ready_15),
    .req_a(req_a), .req_b(req_b), .abort(abort), .link_en(link_en_15),
    .tx_a(tx_a_15), .tx_b(tx_b_15), .rx_byte(rx_byte), .rsp_valid(rsp_valid_15),
    .rsp_data(rsp_data_15), .rsp_ready(rsp_ready), .busy(busy_15), .txn_count(txn_count_15)
  );

  logic        sel15;
  logic        x_req_ready, x_link_en, x_rsp_valid, x_busy;
  logic [7:0]  x_tx_a, x_tx_b, x_txn_count;
  logic [15:0] x_rsp_data;

  always_comb begin
    x_req_ready = sel15 ? req_ready_15 : req_ready_1;
    x_link_en   = sel15 ? link_en_15   : link_en_1;
    x_rsp_valid = sel15 ? rsp_valid_15 : rsp_valid_1;
    x_busy      = sel15 ? busy_15      : busy_1;
    x_tx_a      = sel15 ? tx_a_15      : tx_a_1;
    x_tx_b      = sel15 ? tx_b_15      : tx_b_1;
    x_txn_count = sel15 ? txn_count_15 : txn_count_1;
    x_rsp_data  = sel15 ? rsp_data_15  : rsp_data_1;
  end

  int unsigned n_checks = 0;
  int unsigned n_err = 0;
  logic [7:0]  exp_cnt;
  int          n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [15:0] a, input logic [15:0] b);
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n0, output int nout);
    nout = n0;
    while (!rsp_valid && nout < 40) begin
      tick();
      nout++;
    end
  endtask

  task automatic dwell(input bit use15, input int w);
    int k;
    int lk;
    sel15 = use15;
    rx_seed = 8'h77;
    rsp_ready = 1'b1;
    req_a = 16'h8081;
    req_b = 16'h9091;
    if (use15) req_valid15 = 1'b1; else req_valid1 = 1'b1;
    tick();
    req_valid1 = 1'b0;
    req_valid15 = 1'b0;
    check("dw_tx_a_lo", 32'(x_tx_a), 32'h81);
    check("dw_tx_b_lo", 32'(x_tx_b), 32'h91);
    k = 0;
    lk = 0;
    while (!x_rsp_valid && k < 40) begin
      if (x_link_en) lk++;
      tick();
      k++;
    end
    check("dw_latency", 32'(k), 32'(4 + w));
    check("dw_wait_cycles", 32'(lk - 4), 32'(w));
    check("dw_rsp_data", 32'(x_rsp_data), 32'h7777);
    tick();
    check("dw_req_ready", 32'(x_req_ready), 32'h1);
    check("dw_busy", 32'(x_busy), 32'h0);
    check("dw_txn_count", 32'(x_txn_count), 32'h1);
  endtask

  initial begin
    req_valid = 1'b0; req_valid1 = 1'b0; req_valid15 = 1'b0;
    abort = 1'b0; rsp_ready = 1'b0; sel15 = 1'b0;
    req_a = '0; req_b = '0; rx_seed = '0;

    // reset values
    #12;
    check("rst_link_en", 32'(link_en), 32'h0);
    check("rst_tx_a", 32'(tx_a), 32'h0);
    check("rst_tx_b", 32'(tx_b), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_txn_count", 32'(txn_count), 32'h0);
    check("rst_rsp_data", 32'(rsp_data), 32'h0);
    #8 rst_n = 1'b1;
    tick();
    check("rst_req_ready", 32'(req_ready), 32'h1);

    // basic transaction, rsp_ready already high
    rx_seed = 8'h50;
    rsp_ready = 1'b1;
    start(16'h3C00, 16'h4000);
    check("t1_req_ready_busy", 32'(req_ready), 32'h0);
    check("t1_busy", 32'(busy), 32'h1);
    check("t1_link_lo", 32'(link_en), 32'h1);
    check("t1_tx_a_lo", 32'(tx_a), 32'h00);
    check("t1_tx_b_lo", 32'(tx_b), 32'h00);
    tick();
    check("t1_tx_a_hi", 32'(tx_a), 32'h3C);
    check("t1_tx_b_hi", 32'(tx_b), 32'h40);
    tick();
    check("t1_tx_a_wait", 32'(tx_a), 32'h00);
    check("t1_tx_b_wait", 32'(tx_b), 32'h00);
    check("t1_link_wait", 32'(link_en), 32'h1);
    wait_rsp(2, n);
    check("t1_latency", 32'(n), 32'd6);
    check("t1_rsp_data", 32'(rsp_data), 32'h5554);
    check("t1_link_resp", 32'(link_en), 32'h0);
    tick();
    check("t1_req_ready_after", 32'(req_ready), 32'h1);
    check("t1_rsp_valid_after", 32'(rsp_valid), 32'h0);
    check("t1_txn_count", 32'(txn_count), 32'h1);

    // backpressure in RESP
    rx_seed = 8'h90;
    rsp_ready = 1'b0;
    start(16'hC5A7, 16'h1234);
    check("t2_tx_a_lo", 32'(tx_a), 32'hA7);
    check("t2_tx_b_lo", 32'(tx_b), 32'h34);
    tick();
    check("t2_tx_a_hi", 32'(tx_a), 32'hC5);
    check("t2_tx_b_hi", 32'(tx_b), 32'h12);
    wait_rsp(1, n);
    check("t2_latency", 32'(n), 32'd6);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_hold_valid", 32'(rsp_valid), 32'h1);
      check("t2_hold_data", 32'(rsp_data), 32'h9594);
      check("t2_hold_count", 32'(txn_count), 32'h1);
    end
    rsp_ready = 1'b1;
    tick();
    check("t2_txn_count", 32'(txn_count), 32'h2);
    check("t2_req_ready", 32'(req_ready), 32'h1);

    // abort during WAIT
    start(16'h1111, 16'h2222);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy", 32'(busy), 32'h0);
    check("ab_link_en", 32'(link_en), 32'h0);
    check("ab_rsp_valid", 32'(rsp_valid), 32'h0);
    check("ab_req_ready", 32'(req_ready), 32'h1);
    check("ab_txn_count", 32'(txn_count), 32'h2);
    check("ab_rsp_data_kept", 32'(rsp_data), 32'h9594);
    tick();
    tick();
    check("ab_no_rsp", 32'(rsp_valid), 32'h0);

    // abort in IDLE blocks acceptance
    req_valid = 1'b1;
    abort = 1'b1;
    tick();
    req_valid = 1'b0;
    abort = 1'b0;
    check("ab_idle_block", 32'(busy), 32'h0);

    // reset during SEND_HI
    rx_seed = 8'h20;
    start(16'hABCD, 16'h1357);
    tick();
    check("rs_tx_a_hi", 32'(tx_a), 32'hAB);
    check("rs_tx_b_hi", 32'(tx_b), 32'h13);
    #1 rst_n = 1'b0;
    #1;
    check("rs_link_en", 32'(link_en), 32'h0);
    check("rs_tx_a", 32'(tx_a), 32'h0);
    check("rs_tx_b", 32'(tx_b), 32'h0);
    check("rs_busy", 32'(busy), 32'h0);
    check("rs_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rs_txn_count", 32'(txn_count), 32'h0);
    check("rs_rsp_data", 32'(rsp_data), 32'h0);
    #2 rst_n = 1'b1;
    tick();
    check("rs_req_ready", 32'(req_ready), 32'h1);
    start(16'h4248, 16'h3E00);
    check("rs_tx_a_lo", 32'(tx_a), 32'h48);
    check("rs_tx_b_lo", 32'(tx_b), 32'h00);
    tick();
    check("rs_tx_a_hi2", 32'(tx_a), 32'h42);
    check("rs_tx_b_hi2", 32'(tx_b), 32'h3E);
    wait_rsp(1, n);
    check("rs_latency", 32'(n), 32'd6);
    check("rs_rsp_data2", 32'(rsp_data), 32'h2524);
    tick();
    check("rs_txn_count2", 32'(txn_count), 32'h1);

    // 256 back-to-back transactions, counter wraps
    exp_cnt = 8'h01;
    rsp_ready = 1'b1;
    req_a = 16'h5A5A;
    req_b = 16'hA5A5;
    req_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      n = 0;
      while (!rsp_valid && n < 40) begin
        tick();
        n++;
      end
      check("b2b_rsp_valid", 32'(rsp_valid), 32'h1);
      if (!rsp_valid) break;
      tick();
      exp_cnt = exp_cnt + 8'd1;
      check("b2b_req_ready", 32'(req_ready), 32'h1);
      check("b2b_txn_count", 32'(txn_count), 32'(exp_cnt));
    end
    req_valid = 1'b0;
    check("b2b_wrap", 32'(txn_count), 32'h01);
    tick();

    // RSP_WAIT extremes
    dwell(1'b0, 1);
    dwell(1'b1, 15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/afpm_host_link.md
AFPM_HOST_LINK -- requirements
Module: afpm_host_link

Interface
REQ-001 Parameter RSP_WAIT, default 2: idle link cycles between the high operand byte and the low result byte sample; legal range 1..15.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  host offers an operand pair.
REQ-005 req_ready  output  1  block accepts an operand pair.
REQ-006 req_a  input  16  operand A (binary16: sign[15], exponent[14:10], mantissa[9:0]).
REQ-007 req_b  input  16  operand B, same format.
REQ-008 abort  input  1  synchronous cancel of the current transaction.
REQ-009 link_en  output  1  enable driven to the multiplier's ena pin.
REQ-010 tx_a  output  8  operand A byte lane, driven to the multiplier's ui_in.
REQ-011 tx_b  output  8  operand B byte lane, driven to the multiplier's uio_in.
REQ-012 rx_byte  input  8  result byte lane from the multiplier's uo_out.
REQ-013 rsp_valid  output  1  result available.
REQ-014 rsp_data  output  16  captured result {high byte, low byte}.
REQ-015 rsp_ready  input  1  host consumes the result.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 txn_count  output  8  count of completed response handshakes, wrapping.

Function
REQ-018 The FSM SHALL have states IDLE, SEND_LO, SEND_HI, WAIT, CAP_LO, CAP_HI, and RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; when req_valid and req_ready are both high, req_a and req_b SHALL be latched internally and the next state SHALL be SEND_LO.
REQ-020 SEND_LO SHALL drive tx_a=A[7:0] and tx_b=B[7:0] for exactly one cycle, then go to SEND_HI.
REQ-021 SEND_HI SHALL drive tx_a=A[15:8] and tx_b=B[15:8] for exactly one cycle, then go to WAIT.
REQ-022 tx_a and tx_b SHALL be 8'h00 in every state other than SEND_LO and SEND_HI.
REQ-023 In WAIT, a 4-bit counter SHALL be loaded with RSP_WAIT-1 on entry and decremented each cycle; the FSM SHALL leave for CAP_LO in the cycle the counter reads 0, so it stays exactly RSP_WAIT cycles.
REQ-024 CAP_LO SHALL sample rx_byte into rsp_data[7:0] at the end of its single cycle; CAP_HI SHALL sample rx_byte into rsp_data[15:8], then go to RESP.
REQ-025 link_en SHALL be 1 in SEND_LO, SEND_HI, WAIT, CAP_LO and CAP_HI, and 0 in IDLE and RESP.
REQ-026 In RESP, rsp_valid SHALL be 1 and rsp_data SHALL hold stable until rsp_ready=1.
REQ-027 On rsp_valid and rsp_ready both high, the block SHALL return to IDLE and increment txn_count by 1, wrapping 8'hFF to 8'h00.
REQ-028 rsp_ready already high when RESP is entered SHALL complete the handshake in the first RESP cycle; req_ready SHALL then be 1 in the following cycle, which is the back-to-back minimum.
REQ-029 Latency: with acceptance at edge 0, rsp_valid SHALL first be high in the cycle after edge 4+RSP_WAIT.
REQ-030 abort=1 in any state other than IDLE SHALL force IDLE on the next edge, without a response and without a txn_count increment; abort has priority over every other transition.
REQ-031 abort=1 in IDLE SHALL block acceptance in that cycle.
REQ-032 rsp_data SHALL keep its last captured value until it is overwritten by CAP_LO or CAP_HI; it is not cleared by abort.
REQ-033 req_valid, req_a and req_b SHALL be ignored outside IDLE.

Reset
REQ-034 Asserting rst_n low SHALL asynchronously force: state IDLE, latched operands 0, WAIT counter 0, rsp_data 16'h0000, txn_count 8'h00.
REQ-035 The output reset values SHALL be: req_ready=1 (once rst_n is high), link_en=0, tx_a=8'h00, tx_b=8'h00, rsp_valid=0, busy=0.
REQ-036 Reset asserted mid-transaction SHALL discard the transaction; the first request after deassertion SHALL be processed normally.

Verification
REQ-037 RSP_WAIT=2, req_a=16'h3C00, req_b=16'h4000, rsp_ready=1, rx_byte a byte stub -> tx_a/tx_b carry 00/00 then 3C/40 on consecutive cycles; rsp_valid in cycle 7; rsp_data={stub byte at CAP_HI, stub byte at CAP_LO}.
REQ-038 rsp_ready held low for 5 cycles in RESP -> rsp_valid and rsp_data stable throughout; txn_count increments once, when rsp_ready rises.
REQ-039 abort pulsed during WAIT -> IDLE next cycle; link_en=0; no rsp_valid; txn_count unchanged.
REQ-040 rst_n pulsed low during SEND_HI -> all outputs at reset values immediately; a new request afterwards completes with correct bytes.
REQ-041 256 back-to-back transactions with rsp_ready=1 -> txn_count wraps to 8'h00; req_ready high exactly one cycle after each handshake.
REQ-042 RSP_WAIT=1 and RSP_WAIT=15 -> the WAIT dwell is exactly 1 and 15 cycles respectively.
